sobel_edge_filter: RTL and testbench
====================================

# sobel_edge_filter

Streaming 3x3 Sobel edge detector between the OV7670 capture stage and the frame buffer. Consumes raster-ordered RGB444 camera pixels, converts them to 8-bit luma, computes |Gx|+|Gy| over a 3x3 window using two on-chip line buffers, and writes one result per pixel into the frame buffer. The display interface reads these results back in greyscale mode. A bypass mode writes raw RGB444 pixels instead.

## Interface
Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- ADDR_W, 19: frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- i_clk  in  1  pixel/system clock; all logic on the rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_bypass  in  1  1 = write raw pixels, 0 = write Sobel magnitude; sampled only on an accepted SOF pixel.
- i_pix_valid  in  1  input pixel strobe; one pixel is accepted per cycle when high.
- i_pix_sof  in  1  start of frame; qualified by i_pix_valid and marks pixel (0,0).
- i_pix_data  in  12  pixel as {B[11:8], G[7:4], R[3:0]}.
- o_we  out  1  frame buffer write enable.
- o_waddr  out  ADDR_W  write address, raster index y*WIDTH+x.
- o_wdata  out  12  write data: {4'h0, mag[7:0]} in Sobel mode, raw pixel in bypass mode.
- o_busy  out  1  high from an accepted SOF until the last write of that frame.
- o_frame_done  out  1  one-cycle pulse coincident with the final write of a frame.

## Operation
- FSM states:
  - IDLE: waits for i_pix_valid & i_pix_sof. Pixels arriving without SOF are dropped.
  - RUN: accepts pixels. The raster counters x (0..WIDTH-1) and y (0..HEIGHT-1) advance per accepted pixel.
  - FLUSH: Sobel mode only; emits the final WIDTH+1 outputs at one per cycle while ignoring input.
- Transitions:
  - IDLE -> RUN on SOF.
  - RUN -> FLUSH on acceptance of pixel (WIDTH-1, HEIGHT-1) in Sobel mode.
  - RUN -> IDLE on that same pixel in bypass mode.
  - FLUSH -> IDLE after its WIDTH+1 issues.
- SOF accepted in RUN or FLUSH: the current frame is abandoned with no further writes for it, and no o_frame_done. Counters reset, the SOF pixel becomes (0,0), and the state goes to RUN. Line buffer contents are not cleared.
- Luma:
  - Expand each channel by nibble replication (c8 = {c4,c4}).
  - Y = (77*R8 + 150*G8 + 29*B8) >> 8, using 16-bit unsigned intermediates. Y is 8 bits; the max value is 255.
- Window:
  - Line buffers hold the previous two lines of Y (WIDTH x 8 bits each).
  - The 3x3 window is shifted once per accepted pixel.
  - The pixel at raster index n completes the window centred on index m = n-(WIDTH+1).
- Gradient:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20).
  - Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Both are signed 11-bit. mag = |Gx|+|Gy| (11-bit unsigned, max 2040), saturated to 255.
- Border: a centre in row 0, row HEIGHT-1, column 0 or column WIDTH-1 writes mag = 0. No wrap-around across lines.
- Sobel mode: exactly WIDTH*HEIGHT writes per frame, to addresses 0..WIDTH*HEIGHT-1 in ascending order.
  - The first WIDTH+1 accepted pixels produce no write.
  - All FLUSH outputs are border pixels (value 0).
- Bypass mode: pixel n is written unchanged to address n. No lag, no flush.

## Timing
- Reset values:
  - o_we=0, o_waddr=0, o_wdata=0, o_busy=0, o_frame_done=0.
  - State is IDLE; x=y=0. Line buffer contents are don't-care.
- Latency: o_we asserts exactly 2 cycles after the accepting (or FLUSH-issue) cycle, in both modes.
  - Pipeline: window/luma register, then gradient, then output register.
- Input gaps (i_pix_valid low) stall nothing. The pipeline keeps advancing and no write occurs for idle slots.
- o_busy rises the cycle after SOF is accepted. It falls the cycle after o_frame_done.
- The frame buffer has no backpressure; o_we is fire-and-forget.
- Asynchronous reset mid-frame forces all outputs to reset values immediately. The next write occurs only after a new SOF.

## Test plan
- Uniform frame, all pixels 12'h888, Sobel mode: 307200 writes, every o_wdata = 0, addresses 0..307199 in order, a single o_frame_done with address 307199.
- Vertical edge, x<320 = 12'h000 and x>=320 = 12'hFFF: interior writes at x=319 and x=320 = 12'h0FF (saturated); all other writes 0; column 0/639 and row 0/479 are 0.
- Bypass mode, incrementing pixel data n[11:0]: write n at address n, 2-cycle latency, no flush, o_frame_done on address 307199.
- Continuous input with i_pix_valid at 50% duty: same write contents and addresses as continuous input; FLUSH runs at 1 write/cycle (641 cycles).
- SOF re-asserted at pixel 1000: no o_frame_done for the aborted frame; address restarts at 0 after 641 further pixels; the following frame completes normally.
- i_rstn pulsed low during FLUSH: o_we drops the same cycle; pixels without SOF afterwards produce no writes.

Source files
------------

// File: rtl/sobel_edge_filter.sv
`timescale 1ns/1ps
// sobel_edge_filter
// Streaming 3x3 Sobel edge detector. Raster-ordered RGB444 pixels are turned
// into 8-bit luma. Two line buffers and a 3x3 window produce |Gx|+|Gy|,
// saturated to 255, and one result per pixel is written to the frame buffer.
// Bypass mode writes the raw pixel instead.
//
// Ports:
//   i_clk          pixel/system clock, rising edge
//   i_rstn         asynchronous active-low reset
//   i_bypass       1 = raw pixels, 0 = Sobel magnitude (sampled on accepted SOF)
//   i_pix_valid    input pixel strobe
//   i_pix_sof      start of frame, qualified by i_pix_valid
//   i_pix_data     pixel {B[11:8], G[7:4], R[3:0]}
//   o_we           frame buffer write enable
//   o_waddr        raster write address y*WIDTH+x
//   o_wdata        {4'h0, mag} (Sobel) or raw pixel (bypass)
//   o_busy         high from the cycle after SOF until the cycle after o_frame_done
//   o_frame_done   pulse coincident with the final write of a frame
module sobel_edge_filter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_bypass,
    input  logic              i_pix_valid,
    input  logic              i_pix_sof,
    input  logic [11:0]       i_pix_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [11:0]       o_wdata,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;       // next write address of the current frame
    logic              bypass_q;
    logic              sof_d1;

    logic              sof_acc, pix_take, mode, issue, border, last_issue, kill, end_pix;
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic [ADDR_W-1:0] cur_addr;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        if (sof_acc) begin
            state_nx = RUN;            // SOF always (re)starts a frame
        end else begin
            case (state)
                RUN:     if (end_pix)    state_nx = bypass_q ? IDLE : FLUSH;
                FLUSH:   if (last_issue) state_nx = IDLE;
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs (issue control) ----------------
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        sof_acc    = i_pix_valid && i_pix_sof;
        pix_take   = sof_acc || (state == RUN && i_pix_valid);
        mode       = sof_acc ? i_bypass : bypass_q;
        cur_x      = sof_acc ? '0 : x_q;
        cur_y      = sof_acc ? '0 : y_q;
        cur_addr   = sof_acc ? '0 : addr_q;
        end_pix    = pix_take && cur_x == X_LAST && cur_y == Y_LAST;
        kill       = sof_acc && state != IDLE;   // abandon the write still in flight
        issue      = 1'b0;
        border     = 1'b0;
        if (pix_take) begin
            // Sobel output lags by WIDTH+1 pixels; the window centre is
            // (x-1, y-1), or the right column of row y-2 when x == 0.
            issue  = mode || (cur_y >= YW'(2)) || (cur_y == YW'(1) && cur_x != '0);
            border = !mode && (cur_x <= XW'(1) || cur_y == YW'(1));
        end else if (state == FLUSH) begin
            issue  = 1'b1;
            border = 1'b1;                        // flush centres are all on the last rows
        end
        last_issue = issue && cur_addr == A_LAST;
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            bypass_q <= 1'b0;
            sof_d1   <= 1'b0;
        end else begin
            sof_d1 <= sof_acc;
            if (sof_acc) bypass_q <= i_bypass;
            if (pix_take) begin
                if (end_pix) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (cur_x == X_LAST) begin
                    x_q <= '0;
                    y_q <= cur_y + YW'(1);
                end else begin
                    x_q <= cur_x + XW'(1);
                    y_q <= cur_y;
                end
            end
            if (issue)        addr_q <= cur_addr + ADDR_W'(1);
            else if (sof_acc) addr_q <= '0;
        end
    end

    // ---------------- luma ----------------
    logic [7:0]  r8, g8, b8, luma;
    logic [15:0] luma_sum;

    always_comb begin
        r8       = {i_pix_data[3:0],  i_pix_data[3:0]};
        g8       = {i_pix_data[7:4],  i_pix_data[7:4]};
        b8       = {i_pix_data[11:8], i_pix_data[11:8]};
        luma_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
        luma     = 8'(luma_sum >> 8);
    end

    // ---------------- line buffers and window (stage 1 data) ----------------
    logic [7:0] lb0 [WIDTH];   // previous line
    logic [7:0] lb1 [WIDTH];   // line before that
    logic [7:0] win [3][3];    // [row][col], row 0 oldest, col 2 newest

    // NOTE: line buffers and window are left out of reset; their contents only reach border outputs before being refilled.
    always_ff @(posedge i_clk) begin
        if (pix_take) begin
            lb1[cur_x] <= lb0[cur_x];
            lb0[cur_x] <= luma;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[cur_x];
            win[1][2] <= lb0[cur_x];
            win[2][2] <= luma;
        end
    end

    // ---------------- stage 1 control ----------------
    logic              s1_valid, s1_last, s1_border, s1_bypass;
    logic [ADDR_W-1:0] s1_addr;
    logic [11:0]       s1_raw;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_border <= 1'b0;
            s1_bypass <= 1'b0;
            s1_addr   <= '0;
            s1_raw    <= '0;
        end else begin
            s1_valid  <= issue;
            s1_last   <= last_issue;
            s1_border <= border;
            s1_bypass <= mode;
            s1_addr   <= cur_addr;
            s1_raw    <= i_pix_data;
        end
    end

    // ---------------- gradient (combinational between the two stages) ----------------
    // Differences are kept as 11-bit two's complement; the sign bit selects negation.
    logic [10:0] gx_p, gx_n, gy_p, gy_n, gx, gy, ax, ay, mag;
    logic [7:0]  mag_sat;

    always_comb begin
        gx_p    = 11'(win[0][2]) + 11'({win[1][2], 1'b0}) + 11'(win[2][2]);
        gx_n    = 11'(win[0][0]) + 11'({win[1][0], 1'b0}) + 11'(win[2][0]);
        gy_p    = 11'(win[2][0]) + 11'({win[2][1], 1'b0}) + 11'(win[2][2]);
        gy_n    = 11'(win[0][0]) + 11'({win[0][1], 1'b0}) + 11'(win[0][2]);
        gx      = gx_p - gx_n;
        gy      = gy_p - gy_n;
        ax      = gx[10] ? 11'd0 - gx : gx;
        ay      = gy[10] ? 11'd0 - gy : gy;
        mag     = ax + ay;
        mag_sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end

    // ---------------- output register ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_we         <= s1_valid && !kill;
            o_frame_done <= s1_valid && s1_last && !kill;
            o_waddr      <= s1_addr;
            o_wdata      <= s1_bypass ? s1_raw : {4'h0, (s1_border ? 8'h00 : mag_sat)};
            // A SOF accepted the cycle before a done belongs to a newer frame,
            // so that done must not drop busy.
            o_busy       <= sof_acc || (o_busy && !(o_frame_done && !sof_d1));
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
`timescale 1ns/1ps
// Self-checking bench for sobel_edge_filter on a small 8x6 frame.
// A reference model computes each expected write from whole-frame arrays;
// the driver pushes expectations as pixels are issued and a monitor on the
// falling edge pops and compares every write.
module tb_sobel_edge_filter;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int AW   = 6;
    localparam int NPIX = W * H;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_bypass = 1'b0;
    logic          i_pix_valid = 1'b0;
    logic          i_pix_sof = 1'b0;
    logic [11:0]   i_pix_data = '0;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [11:0]   o_wdata;
    logic          o_busy;
    logic          o_frame_done;

    sobel_edge_filter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_bypass     (i_bypass),
        .i_pix_valid  (i_pix_valid),
        .i_pix_sof    (i_pix_sof),
        .i_pix_data   (i_pix_data),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int writes_seen = 0;

    typedef struct {
        int addr;
        int data;
        bit done;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   frame_pix [NPIX];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int luma_ref(input int p);
        int r8, g8, b8;
        r8 = (p & 15) * 17;
        g8 = ((p >> 4) & 15) * 17;
        b8 = ((p >> 8) & 15) * 17;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    function automatic int y_at(input int x, input int y);
        return luma_ref(frame_pix[y * W + x]);
    endfunction

    function automatic int sobel_ref(input int m);
        int cx, cy, gx, gy, mag;
        cx = m % W;
        cy = m / W;
        if (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1) return 0;
        gx = (y_at(cx+1, cy-1) + 2 * y_at(cx+1, cy) + y_at(cx+1, cy+1))
           - (y_at(cx-1, cy-1) + 2 * y_at(cx-1, cy) + y_at(cx-1, cy+1));
        gy = (y_at(cx-1, cy+1) + 2 * y_at(cx, cy+1) + y_at(cx+1, cy+1))
           - (y_at(cx-1, cy-1) + 2 * y_at(cx, cy-1) + y_at(cx+1, cy-1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
    endfunction

    // kind: 0 uniform 888, 1 vertical edge, 2 random, 3 incrementing
    task automatic fill(input int kind);
        for (int n = 0; n < NPIX; n++) begin
            case (kind)
                0:       frame_pix[n] = 'h888;
                1:       frame_pix[n] = ((n % W) < W / 2) ? 'h000 : 'hFFF;
                2:       frame_pix[n] = int'($urandom_range(4095));
                default: frame_pix[n] = n & 'hFFF;
            endcase
        end
    endtask

    task automatic push(input int a, input int d, input bit dn, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.done = dn;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (i_rstn && (o_we || o_frame_done)) begin
            writes_seen++;
            if (!o_we) begin
                check("frame_done_without_we", int'(o_we), 1);
            end else if (exp_q.size() == 0) begin
                check("write_when_none_expected", int'(o_we), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", int'(o_waddr), mon_e.addr);
                check("wdata", int'(o_wdata), mon_e.data);
                check("frame_done", int'(o_frame_done), int'(mon_e.done));
                check("write_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic idle_cycle();
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'($urandom_range(1));
        i_pix_data  = 12'($urandom);
        i_bypass    = 1'($urandom_range(1));
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) idle_cycle();
    endtask

    task automatic drive(input logic [11:0] d, input logic sof, input logic byp);
        i_pix_valid = 1'b1;
        i_pix_sof   = sof;
        i_pix_data  = d;
        i_bypass    = byp;
        @(posedge i_clk);
        #1;
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'b0;
    endtask

    task automatic pulse_reset();
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'b0;
        check("we_before_reset", int'(o_we), 1);
        #1;
        i_rstn = 1'b0;
        #1;
        check("reset_we", int'(o_we), 0);
        check("reset_waddr", int'(o_waddr), 0);
        check("reset_wdata", int'(o_wdata), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_frame_done", int'(o_frame_done), 0);
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
    endtask

    // abort_at > 0: stop after that many pixels (a later SOF abandons the frame).
    // rst_at >= 0: pulse reset at that FLUSH cycle.
    task automatic run_frame(input bit byp, input int gap_pct, input int abort_at, input int rst_at);
        int n_end;
        n_end = (abort_at > 0) ? abort_at : NPIX;
        for (int n = 0; n < n_end; n++) begin
            while (n > 0 && int'($urandom_range(99)) < gap_pct) idle_cycle();
            if (byp)
                push(n, frame_pix[n], n == NPIX - 1, cyc + 2);
            else if (n >= W + 1)
                push(n - W - 1, sobel_ref(n - W - 1), 1'b0, cyc + 2);
            drive(12'(frame_pix[n]), n == 0, (n == 0) ? byp : 1'($urandom_range(1)));
            if (n == 0) check("busy_after_sof", int'(o_busy), 1);
        end
        if (abort_at == 0 && !byp) begin
            for (int j = 0; j <= W; j++)
                push(NPIX - W - 1 + j, 0, j == W, cyc + 2 + j);
            for (int j = 0; j <= W; j++) begin
                if (j == rst_at) begin
                    pulse_reset();
                    break;
                end
                drive(12'($urandom), 1'b0, 1'($urandom_range(1)));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) idle_cycle();
        check("drain_queue_empty", exp_q.size(), 0);
        idle(2);
        check("busy_low_after_frame", int'(o_busy), 0);
    endtask

    // ---------------- main sequence ----------------
    int ws;

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_we", int'(o_we), 0);
        check("rst_waddr", int'(o_waddr), 0);
        check("rst_wdata", int'(o_wdata), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        i_rstn = 1'b1;
        idle(2);

        // Pixels without SOF in IDLE are dropped.
        for (int i = 0; i < 5; i++) drive(12'($urandom), 1'b0, 1'b0);
        idle(4);
        check("no_writes_before_sof", writes_seen, 0);

        fill(0); run_frame(1'b0, 0, 0, -1);  drain();   // uniform
        fill(1); run_frame(1'b0, 0, 0, -1);  drain();   // vertical edge
        fill(2); run_frame(1'b0, 50, 0, -1); drain();   // random, 50% gaps
        fill(3); run_frame(1'b1, 0, 0, -1);  drain();   // bypass incrementing
        fill(2); run_frame(1'b1, 50, 0, -1); drain();   // bypass random, gaps

        // Sobel frame abandoned by a new SOF, then a full frame.
        fill(2); run_frame(1'b0, 0, 20, -1); idle(3);
        fill(2); run_frame(1'b0, 20, 0, -1); drain();

        // Bypass frame abandoned, then a Sobel frame.
        fill(3); run_frame(1'b1, 0, 10, -1); idle(3);
        fill(2); run_frame(1'b0, 0, 0, -1);  drain();

        // Reset during FLUSH, then pixels without SOF, then a new frame.
        fill(2); run_frame(1'b0, 0, 0, 3);
        ws = writes_seen;
        for (int i = 0; i < 12; i++) drive(12'($urandom), 1'b0, 1'b0);
        idle(4);
        check("no_writes_after_reset", writes_seen - ws, 0);
        fill(2); run_frame(1'b0, 30, 0, -1); drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
